// File: rtl/alu_batch_packer.sv
// ============================================================================
// alu_batch_packer : packs {a,b,op} requests into a lane-packed batch word
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_batch_packer #(
  parameter  int LANES  = 6,
  parameter  int LANE_W = 10,
  parameter  int OUT_W  = 128,
  localparam int CNT_W  = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_a,
  input  logic [3:0]         req_b,
  input  logic [1:0]         req_op,
  input  logic               flush,
  output logic               bat_valid,
  input  logic               bat_ready,
  output logic [OUT_W-1:0]   bat_data,
  output logic [CNT_W-1:0]   bat_count,
  output logic [LANES-1:0]   bat_mask
);

  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
  logic [DATA_W-1:0]   r_data,  w_data_nxt;
  logic [LANES-1:0]    r_mask,  w_mask_nxt;
  logic                w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

  assign w_accept = req_valid && (r_state == FILL);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    unique case (r_state)
      FILL: begin
        if (w_accept) begin
          for (int i = 0; i < LANES; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              w_data_nxt[LANE_W*i +: LANE_W] = {req_a, req_b, req_op};
              w_mask_nxt[i]                  = 1'b1;
            end
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // A flush closes the batch only if it will hold at least one lane.
        if ((w_accept && (r_cnt == CNT_W'(LANES - 1))) ||
            (flush && ((r_cnt != '0) || w_accept))) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bat_ready) begin
          w_state_nxt = FILL;
          w_cnt_nxt   = '0;
          w_data_nxt  = '0;
          w_mask_nxt  = '0;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign req_ready = (r_state == FILL);
  assign bat_valid = (r_state == HOLD);
  assign bat_count = (r_state == HOLD) ? r_cnt : '0;
  assign bat_mask  = r_mask;

  always_comb begin
    bat_data             = '0;
    bat_data[DATA_W-1:0] = r_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_batch_packer.sv
// ============================================================================
// tb_alu_batch_packer : randomized self-checking bench for alu_batch_packer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_batch_packer;

  localparam int LANES  = 6;
  localparam int LANE_W = 10;
  localparam int OUT_W  = 128;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_a, req_b;
  logic [1:0]       req_op;
  logic             flush, bat_valid, bat_ready;
  logic [OUT_W-1:0] bat_data;
  logic [2:0]       bat_count;
  logic [LANES-1:0] bat_mask;

  int n_vec = 0;
  int n_err = 0;

  // Reference: queue of accepted lane words and whether a batch is on offer.
  logic [LANE_W-1:0] m_q[$];
  bit                m_hold = 1'b0;

  always #5 clk = ~clk;

  alu_batch_packer #(.LANES(LANES), .LANE_W(LANE_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .flush(flush),
    .bat_valid(bat_valid), .bat_ready(bat_ready),
    .bat_data(bat_data), .bat_count(bat_count), .bat_mask(bat_mask)
  );

  function automatic logic [OUT_W-1:0] m_pack();
    logic [OUT_W-1:0] r = '0;
    foreach (m_q[i]) r = r | (OUT_W'(m_q[i]) << (LANE_W * i));
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] pack_list(input logic [LANE_W-1:0] w[LANES], input int n);
    logic [OUT_W-1:0] r = '0;
    for (int i = 0; i < n; i++) r = r + (OUT_W'(w[i]) << (LANE_W * i));
    return r;
  endfunction

  // Drive one cycle of inputs, advance the reference across the edge, end at negedge.
  task automatic tick(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic fl, input logic br);
    req_valid = v; req_a = a; req_b = b; req_op = op; flush = fl; bat_ready = br;
    @(posedge clk);
    if (!m_hold) begin
      if (v) m_q.push_back({a, b, op});
      if (m_q.size() == LANES || (fl && m_q.size() != 0)) m_hold = 1'b1;
    end else if (br) begin
      m_q.delete();
      m_hold = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    n_vec++; if (bat_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bat_valid); end
    n_vec++; if (bat_data !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bat_data); end
    n_vec++; if (bat_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bat_count); end
    n_vec++; if (bat_mask !== 6'h00) begin n_err++; $display("FAIL reset_mask got=%h exp=0", bat_mask); end
  endtask

  task automatic test_full_batch();
    for (int i = 0; i < LANES; i++) begin
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_ready lane=%0d got=%b exp=1", i, req_ready); end
      tick(1, 4'hF, 4'hF, 2'd3, 0, 1);
      if (i < LANES - 1) begin
        n_vec++; if (bat_valid !== 1'b0) begin n_err++; $display("FAIL full_early_valid lane=%0d got=%b exp=0", i, bat_valid); end
      end
    end
    n_vec++; if (bat_valid !== 1'b1) begin n_err++; $display("FAIL full_valid got=%b exp=1", bat_valid); end
    n_vec++; if (bat_data !== 128'h0FFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL full_data got=%h exp=0fffffffffffffff", bat_data); end
    n_vec++; if (bat_count !== 3'd6) begin n_err++; $display("FAIL full_count got=%0d exp=6", bat_count); end
    n_vec++; if (bat_mask !== 6'h3F) begin n_err++; $display("FAIL full_mask got=%h exp=3f", bat_mask); end
    tick(1, 4'h1, 4'h2, 2'd0, 0, 1);
    n_vec++; if (bat_valid !== 1'b0) begin n_err++; $display("FAIL full_one_cycle got=%b exp=0", bat_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL full_next_ready got=%b exp=1", req_ready); end
    tick(1, 4'h1, 4'h2, 2'd0, 0, 1);
    tick(0, 4'h0, 4'h0, 2'd0, 1, 1);
    n_vec++; if (bat_data !== 128'h48 || bat_count !== 3'd1) begin
      n_err++; $display("FAIL full_next_lane0 got=%h/%0d exp=48/1", bat_data, bat_count);
    end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  task automatic test_flush_partial();
    tick(1, 4'h1, 4'h2, 2'd0, 0, 1);
    tick(1, 4'h3, 4'h1, 2'd1, 0, 1);
    n_vec++; if (bat_valid !== 1'b0) begin n_err++; $display("FAIL flush_pre_valid got=%b exp=0", bat_valid); end
    tick(0, 4'h0, 4'h0, 2'd0, 1, 0);
    n_vec++; if (bat_data !== 128'h31448) begin n_err++; $display("FAIL flush_data got=%h exp=31448", bat_data); end
    n_vec++; if (bat_count !== 3'd2) begin n_err++; $display("FAIL flush_count got=%0d exp=2", bat_count); end
    n_vec++; if (bat_mask !== 6'h03) begin n_err++; $display("FAIL flush_mask got=%h exp=03", bat_mask); end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
    n_vec++; if (bat_valid !== 1'b0 || bat_count !== 3'd0) begin
      n_err++; $display("FAIL flush_release got=%b/%0d exp=0/0", bat_valid, bat_count);
    end
  endtask

  task automatic test_accept_flush();
    tick(1, 4'h1, 4'h2, 2'd0, 0, 0);
    tick(1, 4'h3, 4'h1, 2'd1, 1, 0);
    n_vec++; if (bat_valid !== 1'b1) begin n_err++; $display("FAIL accflush_valid got=%b exp=1", bat_valid); end
    n_vec++; if (bat_data !== 128'h31448) begin n_err++; $display("FAIL accflush_data got=%h exp=31448", bat_data); end
    n_vec++; if (bat_count !== 3'd2) begin n_err++; $display("FAIL accflush_count got=%0d exp=2", bat_count); end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [LANE_W-1:0] w[LANES];
    logic [OUT_W-1:0]  exp_data;
    for (int i = 0; i < LANES; i++) begin
      w[i] = LANE_W'($urandom);
      tick(1, w[i][9:6], w[i][5:2], w[i][1:0], 0, 0);
    end
    exp_data = pack_list(w, LANES);
    for (int c = 0; c < 5; c++) begin
      tick(1, 4'h5, 4'h6, 2'd2, 0, 0);
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, req_ready); end
      n_vec++; if (bat_data !== exp_data) begin n_err++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, bat_data, exp_data); end
    end
    tick(1, 4'h5, 4'h6, 2'd2, 0, 1);
    n_vec++; if (bat_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release valid=%b ready=%b exp=0/1", bat_valid, req_ready);
    end
    tick(1, 4'h5, 4'h6, 2'd2, 1, 0);
    n_vec++; if (bat_data !== 128'h15A || bat_mask !== 6'h01) begin
      n_err++; $display("FAIL bp_held_lane0 got=%h/%h exp=15a/01", bat_data, bat_mask);
    end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  task automatic test_empty_flush();
    tick(0, 4'h0, 4'h0, 2'd0, 1, 0);
    n_vec++; if (bat_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL empty_flush valid=%b ready=%b exp=0/1", bat_valid, req_ready);
    end
    tick(1, 4'h7, 4'h7, 2'd1, 0, 0);
    tick(0, 4'h0, 4'h0, 2'd0, 1, 0);
    n_vec++; if (bat_data !== 128'h1DD || bat_count !== 3'd1) begin
      n_err++; $display("FAIL empty_flush_after got=%h/%0d exp=1dd/1", bat_data, bat_count);
    end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  task automatic test_reset_midfill();
    logic [LANE_W-1:0] w[LANES];
    logic [OUT_W-1:0]  exp_data;
    for (int i = 0; i < 3; i++) tick(1, 4'($urandom), 4'($urandom), 2'($urandom), 0, 0);
    req_valid = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    m_q.delete(); m_hold = 1'b0;
    n_vec++; if (req_ready !== 1'b1 || bat_valid !== 1'b0 || bat_count !== 3'd0) begin
      n_err++; $display("FAIL rstmid_ctrl ready=%b valid=%b count=%0d exp=1/0/0", req_ready, bat_valid, bat_count);
    end
    n_vec++; if (bat_data !== '0 || bat_mask !== 6'h00) begin
      n_err++; $display("FAIL rstmid_data got=%h/%h exp=0/0", bat_data, bat_mask);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LANES; i++) begin
      w[i] = LANE_W'($urandom);
      tick(1, w[i][9:6], w[i][5:2], w[i][1:0], 0, 0);
    end
    exp_data = pack_list(w, LANES);
    n_vec++; if (bat_data !== exp_data) begin n_err++; $display("FAIL rstmid_batch got=%h exp=%h", bat_data, exp_data); end
    n_vec++; if (bat_mask !== 6'h3F || bat_count !== 3'd6) begin
      n_err++; $display("FAIL rstmid_mask got=%h/%0d exp=3f/6", bat_mask, bat_count);
    end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] exp_data;
    logic [LANES-1:0] exp_mask;
    for (int c = 0; c < 400; c++) begin
      tick(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      n_vec++; if (bat_valid !== m_hold || req_ready !== !m_hold) begin
        n_err++; $display("FAIL rand_hs cyc=%0d valid=%b ready=%b exp_valid=%b", c, bat_valid, req_ready, m_hold);
      end
      n_vec++; if (bat_count !== (m_hold ? 3'(m_q.size()) : 3'd0)) begin
        n_err++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, bat_count, m_hold ? m_q.size() : 0);
      end
      if (m_hold) begin
        exp_data = m_pack();
        exp_mask = LANES'((1 << m_q.size()) - 1);
        n_vec++; if (bat_data !== exp_data || bat_mask !== exp_mask) begin
          n_err++; $display("FAIL rand_batch cyc=%0d got=%h/%h exp=%h/%h", c, bat_data, bat_mask, exp_data, exp_mask);
        end
      end
    end
    tick(0, 4'h0, 4'h0, 2'd0, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    flush = 1'b0; bat_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_full_batch();
    test_flush_partial();
    test_accept_flush();
    test_backpressure();
    test_empty_flush();
    test_reset_midfill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exceeded 200000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/alu_batch_packer.md
# alu_batch_packer

Upstream feeder for the six-lane ALU interface array. It accepts single ALU requests {a, b, op} over a valid/ready stream and packs them into the 128-bit lane-packed word that the array consumes. Once the batch is full or flushed, it presents the word with valid/ready backpressure. It also reports a lane-occupancy mask so the downstream result stage can ignore lanes that hold no request.

## Interface
- LANES, 6, number of ALU lanes per batch.
- LANE_W, 10, bits per lane: {a[3:0], b[3:0], op[1:0]}.
- OUT_W, 128, batch word width; must be ≥ LANES*LANE_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  packer can accept a request this cycle.
- req_a  in  4  operand a.
- req_b  in  4  operand b.
- req_op  in  2  0=add, 1=sub, 2=and, 3=or. Passed through unmodified.
- flush  in  1  close a partial batch.
- bat_valid  out  1  batch word valid.
- bat_ready  in  1  downstream accepts the batch.
- bat_data  out  OUT_W  packed batch word.
- bat_count  out  $clog2(LANES+1)  number of filled lanes, 1..LANES, when bat_valid is high.
- bat_mask  out  LANES  bit i is high when lane i holds a request.

## Operation
- Lane packing:
  - Lane i occupies bat_data[LANE_W*i +: LANE_W] = {a, b, op}.
  - Lane LANES-1 is in the most significant position.
  - Bits [OUT_W-1 : LANES*LANE_W] are always 0.
  - Unfilled lanes are 0.
- State machine with two states, FILL and HOLD; the reset state is FILL.
  - In FILL, req_ready=1 and bat_valid=0.
  - An accept (req_valid & req_ready) writes the request into lane cnt, sets mask[cnt], and increments cnt.
  - FILL→HOLD on the edge where the accept makes cnt==LANES.
  - FILL→HOLD on the edge where flush=1 and (cnt>0 or an accept occurs that cycle).
  - Simultaneous accept+flush: the accepted request is included in the batch.
  - flush with cnt==0 and no accept is ignored. flush is not sticky.
  - In HOLD, req_ready=0, bat_valid=1, and bat_count=cnt.
  - HOLD→FILL on bat_ready=1. On that edge, cnt, data and mask are all cleared.
  - flush during HOLD is ignored.
- Ordering: lanes fill in strict 0,1,2,… order of acceptance. Nothing is reordered or dropped.
- bat_data, bat_mask and bat_count are held stable while bat_valid=1 and bat_ready=0.
- req_a, req_b and req_op are ignored when req_valid=0.

## Timing
- Reset (rst_n low, takes effect immediately):
  - State is FILL, cnt=0, and the data and mask registers are 0.
  - Outputs: req_ready=1, bat_valid=0, bat_data=0, bat_count=0, bat_mask=0.
- Latency: the request that completes a batch is accepted at edge N, and bat_valid is high in the cycle after edge N. There is no combinational path from req_* to bat_*.
- req_ready depends only on state; it has no combinational dependence on req_valid or bat_ready.
- Throughput: with bat_ready held at 1, the packer handles a full batch of LANES requests every LANES+1 cycles. The extra cycle is the HOLD cycle.
- Reset asserted mid-fill or during HOLD discards the partial or pending batch without emitting it.
- bat_count is 0 whenever bat_valid=0.

## Test plan
- Full batch:
  - Stimulus: six back-to-back requests, each a=0xF, b=0xF, op=3, with bat_ready=1.
  - Response: bat_valid is high for exactly one cycle, in the cycle after the 6th accept.
  - Values: bat_data=0x0FFF_FFFF_FFFF_FFFF (upper 68 bits 0), bat_count=6, bat_mask=0x3F.
  - The next request is accepted the following cycle.
- Flush partial:
  - Stimulus: accept (1,2,0), then (3,1,1), then pulse flush.
  - Response: bat_data=0x31448, bat_count=2, bat_mask=0x03.
- Accept+flush same cycle:
  - Stimulus: accept (1,2,0), then in the next cycle accept (3,1,1) with flush=1.
  - Response: bat_valid rises on the following cycle with bat_data=0x31448 and bat_count=2.
- Backpressure:
  - Stimulus: complete a batch, hold bat_ready=0 for 5 cycles, and keep req_valid=1 throughout.
  - Response: req_ready=0 and bat_data stays constant for all 5 cycles, with no request lost.
  - On release, exactly one batch handoff occurs and the held request lands in lane 0 of the next batch.
- Empty flush: flush=1 with cnt=0 and req_valid=0 leaves bat_valid at 0 and the state unchanged.
- Reset mid-fill:
  - Stimulus: accept 3 requests, pulse rst_n low asynchronously, then send 6 new requests.
  - Response: all outputs go to their reset values immediately, and the next batch contains only the 6 new requests with mask 0x3F.
